// File: rtl/grad_dir_scheduler_if.sv
// Job, result and shared-engine signals of the gradient direction scheduler.
// The slave view is the scheduler; the master view is the job source/consumer/engine side.
interface grad_dir_scheduler_if #(
   parameter int pixelBitWidth = 12,
   parameter int gradBitWidth  = 17,
   parameter int NDIR          = 4
);
   logic                              in_valid;
   logic                              in_ready;
   logic [NDIR*5*pixelBitWidth-1:0]   in_e;
   logic [NDIR*pixelBitWidth-1:0]     in_mean;
   logic [pixelBitWidth-1:0]          eng_e1;
   logic [pixelBitWidth-1:0]          eng_e2;
   logic [pixelBitWidth-1:0]          eng_e3;
   logic [pixelBitWidth-1:0]          eng_e4;
   logic [pixelBitWidth-1:0]          eng_e5;
   logic [pixelBitWidth-1:0]          eng_mean;
   logic [gradBitWidth-1:0]           eng_grad;
   logic                              out_valid;
   logic                              out_ready;
   logic [gradBitWidth-1:0]           min_grad;
   logic [1:0]                        min_dir;
   logic [NDIR*gradBitWidth-1:0]      grad_all;

   modport slave (
      input  in_valid, in_e, in_mean, eng_grad, out_ready,
      output in_ready, eng_e1, eng_e2, eng_e3, eng_e4, eng_e5, eng_mean,
             out_valid, min_grad, min_dir, grad_all
   );

   modport master (
      output in_valid, in_e, in_mean, eng_grad, out_ready,
      input  in_ready, eng_e1, eng_e2, eng_e3, eng_e4, eng_e5, eng_mean,
             out_valid, min_grad, min_dir, grad_all
   );
endinterface

// File: rtl/grad_dir_scheduler.sv
// Shares one 5-tap gradient engine across four directions and reports the minimum.
// Optional macro GRAD_PIPE_EN registers eng_grad once before capture (adds a drain cycle).
module grad_dir_scheduler #(
   parameter int pixelBitWidth = 12,
   parameter int gradBitWidth  = 17,
   parameter int NDIR          = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   grad_dir_scheduler_if.slave   bus
);
   localparam int W = pixelBitWidth;
   localparam int G = gradBitWidth;

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [NDIR*5*W-1:0]    e_q, e_d;
   logic [NDIR*W-1:0]      mean_q, mean_d;
   logic [NDIR*G-1:0]      grad_all_q, grad_all_d;
   logic [G-1:0]           min_grad_q, min_grad_d;
   logic [1:0]             min_dir_q, min_dir_d;

   logic                   issue, cap_en;
   logic [1:0]             cap_dir;
   logic [G-1:0]           cap_grad;
   logic [2:0]             last_cnt;
   int                     iss_i, cap_i;

`ifdef GRAD_PIPE_EN
   logic [G-1:0]           grad_p1_q, grad_p1_d;

   // Counter 0..3 issues operands, 1..4 captures the registered result of counter-1.
   always_comb begin
      grad_p1_d = bus.eng_grad;
      issue     = (cnt_q != 3'd4);
      cap_en    = (cnt_q != 3'd0);
      cap_dir   = 2'(cnt_q - 3'd1);
      cap_grad  = grad_p1_q;
      last_cnt  = 3'd4;
   end

   always_ff @(posedge clk) begin
      if (!rst) grad_p1_q <= '0;
      else      grad_p1_q <= grad_p1_d;
   end
`else
   always_comb begin
      issue    = 1'b1;
      cap_en   = 1'b1;
      cap_dir  = cnt_q[1:0];
      cap_grad = bus.eng_grad;
      last_cnt = 3'd3;
   end
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      e_d          = e_q;
      mean_d       = mean_q;
      grad_all_d   = grad_all_q;
      min_grad_d   = min_grad_q;
      min_dir_d    = min_dir_q;
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.eng_e1   = '0;
      bus.eng_e2   = '0;
      bus.eng_e3   = '0;
      bus.eng_e4   = '0;
      bus.eng_e5   = '0;
      bus.eng_mean = '0;
      iss_i        = int'(cnt_q[1:0]);
      cap_i        = int'(cap_dir);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               e_d     = bus.in_e;
               mean_d  = bus.in_mean;
               cnt_d   = 3'd0;
               state_d = EVAL;
            end
         end
         EVAL: begin
            if (issue) begin
               bus.eng_e1   = e_q[(iss_i*5 + 0)*W +: W];
               bus.eng_e2   = e_q[(iss_i*5 + 1)*W +: W];
               bus.eng_e3   = e_q[(iss_i*5 + 2)*W +: W];
               bus.eng_e4   = e_q[(iss_i*5 + 3)*W +: W];
               bus.eng_e5   = e_q[(iss_i*5 + 4)*W +: W];
               bus.eng_mean = mean_q[iss_i*W +: W];
            end
            // Direction 0 seeds the minimum; later ones replace it only when strictly smaller.
            if (cap_en) begin
               grad_all_d[cap_i*G +: G] = cap_grad;
               if ((cap_dir == 2'd0) || (cap_grad < min_grad_q)) begin
                  min_grad_d = cap_grad;
                  min_dir_d  = cap_dir;
               end
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == last_cnt) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         e_q        <= '0;
         mean_q     <= '0;
         grad_all_q <= '0;
         min_grad_q <= '0;
         min_dir_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         e_q        <= e_d;
         mean_q     <= mean_d;
         grad_all_q <= grad_all_d;
         min_grad_q <= min_grad_d;
         min_dir_q  <= min_dir_d;
      end
   end

   assign bus.min_grad = min_grad_q;
   assign bus.min_dir  = min_dir_q;
   assign bus.grad_all = grad_all_q;
endmodule

// File: tb/tb_grad_dir_scheduler.sv
// Scoreboard bench for grad_dir_scheduler: random and directed jobs against a gradient model.
// Timing expectations follow GRAD_PIPE_EN when the macro is defined for the build.
module tb_grad_dir_scheduler;
   localparam int W = 12;
   localparam int G = 17;
   localparam int NDIR = 4;
`ifdef GRAD_PIPE_EN
   localparam int LAT = 6;
   localparam int PERIOD = 7;
`else
   localparam int LAT = 5;
   localparam int PERIOD = 6;
`endif

   typedef struct {
      logic [NDIR*G-1:0] grad_all;
      logic [G-1:0]      min_grad;
      logic [1:0]        min_dir;
      int                acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t cur;
   exp_t nx;
   logic prev_v = 1'b0;
   logic prev_hs = 1'b0;
   logic b2b = 1'b0;
   int   last_acc = -1;
   logic rnd_done;
   logic eng_any;

   grad_dir_scheduler_if #(.pixelBitWidth(W), .gradBitWidth(G), .NDIR(NDIR)) bus ();

   grad_dir_scheduler #(.pixelBitWidth(W), .gradBitWidth(G), .NDIR(NDIR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int absd(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
   endfunction

   // Shared engine stand-in.
   always_comb begin
      bus.eng_grad = G'(absd(bus.eng_mean, bus.eng_e1) + 2*absd(bus.eng_mean, bus.eng_e2)
                      + 4*absd(bus.eng_mean, bus.eng_e3) + 2*absd(bus.eng_mean, bus.eng_e4)
                      + absd(bus.eng_mean, bus.eng_e5));
   end
   assign eng_any = |{bus.eng_e1, bus.eng_e2, bus.eng_e3, bus.eng_e4, bus.eng_e5, bus.eng_mean};

   function automatic exp_t model(input logic [NDIR*5*W-1:0] e, input logic [NDIR*W-1:0] m);
      exp_t r;
      int wt[5];
      int g[NDIR];
      wt = '{1, 2, 4, 2, 1};
      r.grad_all = '0;
      for (int d = 0; d < NDIR; d++) begin
         g[d] = 0;
         for (int k = 0; k < 5; k++) g[d] += wt[k] * absd(m[d*W +: W], e[(d*5+k)*W +: W]);
         r.grad_all[d*G +: G] = G'(g[d]);
      end
      r.min_dir = 2'd0;
      r.min_grad = G'(g[0]);
      for (int d = 1; d < NDIR; d++)
         if (g[d] < int'(r.min_grad)) begin
            r.min_grad = G'(g[d]);
            r.min_dir = 2'(d);
         end
      r.acc_cyc = 0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Stimulus side: predict the response at the moment a job is accepted.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.in_valid && bus.in_ready) begin
         nx = model(bus.in_e, bus.in_mean);
         nx.acc_cyc = cyc;
         q.push_back(nx);
         if (b2b && last_acc >= 0) chk("b2b_period", 128'(cyc - last_acc), 128'(PERIOD));
         last_acc = cyc;
      end
   end

   // Monitor: pop and compare whenever the block presents a result.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         prev_v  = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (prev_hs) begin
            chk("valid_drop", 128'(bus.out_valid), 128'(0));
            chk("ready_after_accept", 128'(bus.in_ready), 128'(1));
         end
         if (bus.out_valid) begin
            chk("ready_low_done", 128'(bus.in_ready), 128'(0));
            chk("eng_zero_done", 128'(eng_any), 128'(0));
            if (!prev_v) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: out_valid with no job pending (cycle %0d)", cyc);
               end else begin
                  cur = q.pop_front();
                  chk("latency", 128'(cyc - cur.acc_cyc), 128'(LAT));
                  chk("min_grad", 128'(bus.min_grad), 128'(cur.min_grad));
                  chk("min_dir", 128'(bus.min_dir), 128'(cur.min_dir));
                  chk("grad_all", 128'(bus.grad_all), 128'(cur.grad_all));
               end
            end else begin
               chk("stable", 128'({bus.grad_all, bus.min_grad, bus.min_dir}),
                   128'({cur.grad_all, cur.min_grad, cur.min_dir}));
            end
         end
         if (bus.in_ready) chk("eng_zero_idle", 128'(eng_any), 128'(0));
         prev_v  = bus.out_valid;
         prev_hs = bus.out_valid && bus.out_ready;
      end
   end

   function automatic logic [NDIR*5*W-1:0] rnd_e(input int mode);
      logic [NDIR*5*W-1:0] r;
      for (int i = 0; i < NDIR*5; i++)
         r[i*W +: W] = (mode == 0) ? W'(100 + $urandom_range(0, 3)) : W'($urandom_range(0, 4095));
      return r;
   endfunction

   function automatic logic [NDIR*W-1:0] rnd_m(input int mode);
      logic [NDIR*W-1:0] r;
      for (int i = 0; i < NDIR; i++)
         r[i*W +: W] = (mode == 0) ? W'(100 + $urandom_range(0, 3)) : W'($urandom_range(0, 4095));
      return r;
   endfunction

   // All tasks start and end just after a rising edge.
   task automatic send(input logic [NDIR*5*W-1:0] e, input logic [NDIR*W-1:0] m);
      int n = 0;
      bus.in_e = e;
      bus.in_mean = m;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
         if (n > 300) begin
            chk("accept_timeout", 128'(0), 128'(1));
            break;
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_e = rnd_e(1);
      bus.in_mean = rnd_m(1);
   endtask

   task automatic wait_valid();
      int n = 0;
      forever begin
         @(negedge clk);
         if (bus.out_valid) break;
         n++;
         if (n > 50) begin
            chk("valid_timeout", 128'(0), 128'(1));
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge clk);
         if (q.size() == 0 && bus.in_ready && !bus.out_valid) break;
         n++;
         if (n > 300) begin
            chk("idle_timeout", 128'(0), 128'(1));
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic directed(input string nm, input logic [NDIR*5*W-1:0] e, input logic [NDIR*W-1:0] m,
                           input logic [NDIR*G-1:0] ga, input logic [G-1:0] mg, input logic [1:0] md);
      bus.out_ready = 1'b0;
      send(e, m);
      wait_valid();
      chk({nm, "_grad_all"}, 128'(bus.grad_all), 128'(ga));
      chk({nm, "_min_grad"}, 128'(bus.min_grad), 128'(mg));
      chk({nm, "_min_dir"}, 128'(bus.min_dir), 128'(md));
      bus.out_ready = 1'b1;
      wait_idle();
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NDIR*5*W-1:0] e;
      logic [NDIR*W-1:0]   m;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_e = '0;
      bus.in_mean = '0;
      rnd_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_outputs", 128'({bus.grad_all, bus.min_grad, bus.min_dir}), 128'(0));
      chk("rst_eng", 128'(eng_any), 128'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // Flat window.
      e = '0;
      m = '0;
      for (int i = 0; i < NDIR*5; i++) e[i*W +: W] = W'(100);
      for (int i = 0; i < NDIR; i++) m[i*W +: W] = W'(100);
      directed("flat", e, m, '0, G'(0), 2'd0);

      // Tap weighting.
      e[(0*5+0)*W +: W] = W'(110);
      e[(1*5+1)*W +: W] = W'(110);
      e[(2*5+2)*W +: W] = W'(105);
      e[(3*5+4)*W +: W] = W'(103);
      directed("weight", e, m, {G'(3), G'(20), G'(20), G'(10)}, G'(3), 2'd3);

      // Tie between directions 1 and 2.
      for (int i = 0; i < NDIR*5; i++) e[i*W +: W] = W'(100);
      e[(0*5+0)*W +: W] = W'(150);
      e[(1*5+0)*W +: W] = W'(101);
      e[(2*5+0)*W +: W] = W'(101);
      e[(3*5+0)*W +: W] = W'(150);
      directed("tie", e, m, {G'(50), G'(1), G'(1), G'(50)}, G'(1), 2'd1);

      // Largest legal gradient in every direction.
      for (int i = 0; i < NDIR*5; i++) e[i*W +: W] = W'(4095);
      directed("max", e, '0, {G'(40950), G'(40950), G'(40950), G'(40950)}, G'(40950), 2'd0);

      // Backpressure with an in_valid pulse that must be ignored.
      bus.out_ready = 1'b0;
      send(rnd_e(1), rnd_m(1));
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = (i == 2);
         bus.in_e = rnd_e(1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      wait_idle();
      send(rnd_e(0), rnd_m(0));
      wait_idle();

      // Reset during EVAL.
      send(rnd_e(1), rnd_m(1));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
      chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
      chk("abort_outputs", 128'({bus.grad_all, bus.min_grad, bus.min_dir}), 128'(0));
      @(posedge clk); #1;
      send(rnd_e(1), rnd_m(1));
      wait_idle();

      // Back-to-back with in_valid and out_ready held high.
      b2b = 1'b1;
      last_acc = -1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5*PERIOD + 2; i++) begin
         bus.in_e = rnd_e(i % 2);
         bus.in_mean = rnd_m(i % 2);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_idle();
      b2b = 1'b0;

      // Random jobs with random backpressure.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               send(rnd_e($urandom_range(0, 1)), rnd_m($urandom_range(0, 1)));
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk); #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("queue_empty", 128'(q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/grad_dir_scheduler.md
Name: grad_dir_scheduler

Overview:
- Time-multiplexes one shared 5-tap directional gradient engine across four interpolation directions (0=N, 1=S, 2=E, 3=W) for one CFA pixel window.
- The engine computes |m-e1| + 2|m-e2| + 4|m-e3| + 2|m-e4| + |m-e5| combinationally and returns a 17-bit result.
- The block captures a job, drives the engine operands one direction per cycle, and collects the four gradients.
- It reports the minimum gradient and its direction to the demosaic interpolation stage through a valid/ready handshake.

Parameters:
- pixelBitWidth, 12, width of pixel and mean operands
- gradBitWidth, 17, width of engine result (pixelBitWidth+5)
- NDIR, 4, number of directions scheduled (fixed at 4; direction index 2 bits)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  job request
- in_ready  output  1  block can accept a job
- in_e  input  NDIR*5*pixelBitWidth  neighbour taps; direction d, tap k (1..5) at bits [(d*5+k-1)*W +: W]
- in_mean  input  NDIR*pixelBitWidth  per-direction mean; direction d at [d*W +: W]
- eng_e1..eng_e5  output  pixelBitWidth each  operands to shared engine
- eng_mean  output  pixelBitWidth  mean operand to shared engine
- eng_grad  input  gradBitWidth  engine result (combinational)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- min_grad  output  gradBitWidth  smallest of the four gradients
- min_dir  output  2  direction index of min_grad
- grad_all  output  NDIR*gradBitWidth  all four gradients; direction d at [d*G +: G]

Behaviour:
- Reset (rst==0 at a clk edge) forces:
  - state=IDLE, in_ready=1, out_valid=0;
  - min_grad=0, min_dir=0, grad_all=0;
  - operand registers=0, direction counter=0.
- Reset overrides all other inputs and aborts any job mid-EVAL or mid-DONE; partial results are discarded.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_e/in_mean into operand registers, clear dir counter, go to EVAL.
- EVAL:
  - in_ready=0.
  - eng_* driven from the latched operands of direction = counter.
  - Each cycle, eng_grad is stored into grad_all slot [counter] and the running minimum is updated.
  - Minimum update rule: replace only if strictly less, so ties keep the lower direction index.
  - The first evaluated direction always initialises the minimum.
  - Counter increments 0..3; after storing direction 3, go to DONE.
- DONE:
  - out_valid=1; min_grad, min_dir, grad_all are stable while waiting.
  - On out_ready, go to IDLE next cycle.
  - out_valid drops the cycle after acceptance.
  - in_valid is ignored in DONE.
- Outside EVAL, eng_* outputs are driven to 0 (no toggling of the shared engine).
- Timing: accept at cycle T, EVAL during T+1..T+4, out_valid at T+5. With out_ready held high, in_ready returns at T+6, giving one job per 6 cycles.
- Arithmetic: eng_grad is treated as unsigned gradBitWidth; comparisons are unsigned. Maximum legal value is 10*(2^W-1)=40950, with no overflow handling required.
- The input bus may change freely after acceptance; only latched operands are used.

Optional Feature:
- GRAD_PIPE_EN defined: eng_grad passes through one register stage before capture.
  - EVAL lasts 5 cycles: four operand-issue cycles plus one drain cycle.
  - Results are written to slot [counter-1]; out_valid at T+6, in_ready at T+7.
  - eng_* drive 0 in the drain cycle.
- Undefined: combinational capture as described in Behaviour.

Test Plan:
- Flat window: all taps=100, all means=100 -> out_valid at T+5, grad_all={0,0,0,0}, min_grad=0, min_dir=0.
- Weighting: dir0 e1=110, dir1 e2=110, dir2 e3=105, dir3 e5=103, all else=100, means=100 -> grad_all={10,20,20,3}, min_grad=3, min_dir=3.
- Tie handling: dir1 and dir2 both e1=101, dir0/dir3 e1=150 -> min_grad=1, min_dir=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and outputs stable, in_ready=0, a pulsed in_valid is ignored; assert out_ready -> IDLE next cycle, next job accepted.
- Reset mid-EVAL: drive rst=0 at T+2 -> next cycle state IDLE, out_valid=0, grad_all=0, in_ready=1; a subsequent job completes correctly.
- Back-to-back and GRAD_PIPE_EN: in_valid and out_ready held high -> accepts every 6 cycles, out_valid at T+5; rebuild with GRAD_PIPE_EN -> accepts every 7 cycles, out_valid at T+6, same result values.
